param_calculator: RTL

PARAM_CALCULATOR -- requirements
Module: param_calculator

---
 rtl/param_calculator.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/param_calculator.sv
// Multi-cycle register-transfer calculator: IDLE->LOAD_A->LOAD_B->EXEC->WRITE->OUT->DONE.
// Optional saturating arithmetic is enabled by defining CALC_SAT_EN.
module param_calculator #(
  parameter int WIDTH = 4,
  parameter int CSW   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic [WIDTH-1:0] out,
  output logic             done,
  output logic             busy,
  output logic             ovf,
  output logic [CSW-1:0]   cs
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD_A = 3'd1;
  localparam logic [2:0] S_LOAD_B = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_WRITE  = 3'd4;
  localparam logic [2:0] S_OUT    = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_XOR = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_ACC = 3'd7;

  localparam logic [31:0] LP_WIDTH = WIDTH;

  logic [2:0]       r_state;
  logic [2:0]       r_state_nxt;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_r1;
  logic [WIDTH-1:0] r_r2;
  logic [WIDTH-1:0] r_r3;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_res;
  logic             r_res_ovf;
  logic             r_r3_ovf;
  logic [WIDTH-1:0] r_out;
  logic             r_ovf;

  logic [WIDTH:0]     w_add;
  logic [WIDTH:0]     w_acc_sum;
  logic [2*WIDTH-1:0] w_shl_full;
  logic [2*WIDTH-1:0] w_shr_full;
  logic [31:0]        w_amt;
  logic               w_big_shift;
  logic [WIDTH-1:0]   w_res;
  logic               w_ovf;

  assign w_add       = {1'b0, r_r1} + {1'b0, r_r2};
  assign w_acc_sum   = {1'b0, r_acc} + {1'b0, r_r1};
  assign w_shl_full  = {{WIDTH{1'b0}}, r_r1} << r_r2;
  assign w_shr_full  = {r_r1, {WIDTH{1'b0}}} >> r_r2;
  assign w_amt       = 32'(r_r2);
  assign w_big_shift = (w_amt >= LP_WIDTH);

  always_comb begin
    w_res = '0;
    w_ovf = 1'b0;
    case (r_op)
      OP_ADD: begin
        w_res = w_add[WIDTH-1:0];
        w_ovf = w_add[WIDTH];
      end
      OP_SUB: begin
        w_res = r_r1 - r_r2;
        w_ovf = (r_r1 < r_r2);
      end
      OP_AND: w_res = r_r1 & r_r2;
      OP_XOR: w_res = r_r1 ^ r_r2;
      OP_OR:  w_res = r_r1 | r_r2;
      OP_SHL: begin
        // A shift of WIDTH or more loses every bit of R1.
        w_res = w_big_shift ? '0 : w_shl_full[WIDTH-1:0];
        w_ovf = w_big_shift ? (|r_r1) : (|w_shl_full[2*WIDTH-1:WIDTH]);
      end
      OP_SHR: begin
        w_res = w_big_shift ? '0 : w_shr_full[2*WIDTH-1:WIDTH];
        w_ovf = w_big_shift ? (|r_r1) : (|w_shr_full[WIDTH-1:0]);
      end
      default: begin
        w_res = w_acc_sum[WIDTH-1:0];
        w_ovf = w_acc_sum[WIDTH];
      end
    endcase
`ifdef CALC_SAT_EN
    if (w_ovf) begin
      if (r_op == OP_ADD || r_op == OP_ACC || r_op == OP_SHL) w_res = '1;
      else if (r_op == OP_SUB) w_res = '0;
    end
`endif
  end

  always_comb begin
    r_state_nxt = S_IDLE;
    case (r_state)
      S_IDLE:   r_state_nxt = go ? S_LOAD_A : S_IDLE;
      S_LOAD_A: r_state_nxt = S_LOAD_B;
      S_LOAD_B: r_state_nxt = S_EXEC;
      S_EXEC:   r_state_nxt = S_WRITE;
      S_WRITE:  r_state_nxt = S_OUT;
      S_OUT:    r_state_nxt = S_DONE;
      default:  r_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_op      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_r1      <= '0;
      r_r2      <= '0;
      r_r3      <= '0;
      r_acc     <= '0;
      r_res     <= '0;
      r_res_ovf <= 1'b0;
      r_r3_ovf  <= 1'b0;
      r_out     <= '0;
      r_ovf     <= 1'b0;
    end else begin
      r_state <= r_state_nxt;
      case (r_state)
        S_IDLE: if (go) begin
          r_op <= op;
          r_a  <= in1;
          r_b  <= in2;
        end
        S_LOAD_A: r_r1 <= r_a;
        S_LOAD_B: r_r2 <= r_b;
        S_EXEC: begin
          r_res     <= w_res;
          r_res_ovf <= w_ovf;
        end
        // Every result is written to both R3 and the accumulator.
        S_WRITE: begin
          r_r3     <= r_res;
          r_acc    <= r_res;
          r_r3_ovf <= r_res_ovf;
        end
        S_OUT: begin
          r_out <= r_r3;
          r_ovf <= r_r3_ovf;
        end
        default: ;
      endcase
    end
  end

  assign out  = r_out;
  assign ovf  = r_ovf;
  assign done = (r_state == S_DONE);
  assign busy = (r_state != S_IDLE);
  assign cs   = CSW'(r_state);

endmodule
